// File: rtl/bus_dest_regbank_pkg.sv
// Datapath-wide bus encoding: sizes and destination slot codes shared by the
// bus-source multiplexer and the destination register bank.
package bus_dest_regbank_pkg;

  localparam int BUS_WIDTH    = 32;
  localparam int BUS_NUM_DEST = 24;
  localparam int BUS_SEL_W    = 5;

  // Slot code N is written by dest_sel N and read back by bus-mux select N.
  typedef enum logic [BUS_SEL_W-1:0] {
    SLOT_R0     = 5'd0,
    SLOT_R1     = 5'd1,
    SLOT_R2     = 5'd2,
    SLOT_R3     = 5'd3,
    SLOT_R4     = 5'd4,
    SLOT_R5     = 5'd5,
    SLOT_R6     = 5'd6,
    SLOT_R7     = 5'd7,
    SLOT_R8     = 5'd8,
    SLOT_R9     = 5'd9,
    SLOT_R10    = 5'd10,
    SLOT_R11    = 5'd11,
    SLOT_R12    = 5'd12,
    SLOT_R13    = 5'd13,
    SLOT_R14    = 5'd14,
    SLOT_R15    = 5'd15,
    SLOT_HI     = 5'd16,
    SLOT_LO     = 5'd17,
    SLOT_ZHI    = 5'd18,
    SLOT_ZLO    = 5'd19,
    SLOT_PC     = 5'd20,
    SLOT_MDR    = 5'd21,
    SLOT_INPORT = 5'd22,
    SLOT_C      = 5'd23
  } slot_code_e;

endpackage

// File: rtl/bus_dest_regbank_dest_decoder.sv
// Destination code decoder: one-hot write enables gated by load, plus a flag
// for codes beyond the implemented slot range.
module bus_dest_regbank_dest_decoder
  import bus_dest_regbank_pkg::*;
#(
  parameter int NUM_DEST = BUS_NUM_DEST,
  parameter int SEL_W    = BUS_SEL_W
) (
  input  logic [SEL_W-1:0]    sel,
  input  logic                en,
  output logic [NUM_DEST-1:0] onehot,
  output logic                out_of_range
);

  always_comb begin
    onehot = '0;
    for (int i = 0; i < NUM_DEST; i++) begin
      if (en && (int'(sel) == i)) onehot[i] = 1'b1;
    end
    out_of_range = en && (int'(sel) >= NUM_DEST);
  end

endmodule

// File: rtl/bus_dest_regbank.sv
// Destination register bank on the shared bus: 24 slots written by code from
// the bus, HI/LO loaded directly by the multiply/divide unit.
module bus_dest_regbank
  import bus_dest_regbank_pkg::*;
#(
  parameter int WIDTH    = BUS_WIDTH,
  parameter int NUM_DEST = BUS_NUM_DEST,
  parameter int SEL_W    = BUS_SEL_W
) (
  input  logic             clock,
  input  logic             clear,
  input  logic [WIDTH-1:0] bus_in,
  input  logic [SEL_W-1:0] dest_sel,
  input  logic             load,
  input  logic             hilo_load,
  input  logic [WIDTH-1:0] hi_in,
  input  logic [WIDTH-1:0] lo_in,
  input  logic             ba_out,
  output logic [WIDTH-1:0] slot_out0,
  output logic [WIDTH-1:0] slot_out1,
  output logic [WIDTH-1:0] slot_out2,
  output logic [WIDTH-1:0] slot_out3,
  output logic [WIDTH-1:0] slot_out4,
  output logic [WIDTH-1:0] slot_out5,
  output logic [WIDTH-1:0] slot_out6,
  output logic [WIDTH-1:0] slot_out7,
  output logic [WIDTH-1:0] slot_out8,
  output logic [WIDTH-1:0] slot_out9,
  output logic [WIDTH-1:0] slot_out10,
  output logic [WIDTH-1:0] slot_out11,
  output logic [WIDTH-1:0] slot_out12,
  output logic [WIDTH-1:0] slot_out13,
  output logic [WIDTH-1:0] slot_out14,
  output logic [WIDTH-1:0] slot_out15,
  output logic [WIDTH-1:0] slot_out16,
  output logic [WIDTH-1:0] slot_out17,
  output logic [WIDTH-1:0] slot_out18,
  output logic [WIDTH-1:0] slot_out19,
  output logic [WIDTH-1:0] slot_out20,
  output logic [WIDTH-1:0] slot_out21,
  output logic [WIDTH-1:0] slot_out22,
  output logic [WIDTH-1:0] slot_out23,
  output logic             write_done,
  output logic [SEL_W-1:0] last_dest,
  output logic             sel_err
);

  localparam int HI_IDX = int'(SLOT_HI);
  localparam int LO_IDX = int'(SLOT_LO);

  logic [NUM_DEST-1:0] bus_wr_en;
  logic                bad_sel;
  logic [NUM_DEST-1:0] wr_en;
  logic [WIDTH-1:0]    wr_data [NUM_DEST];
  logic [WIDTH-1:0]    slot_q  [NUM_DEST];

  bus_dest_regbank_dest_decoder #(
    .NUM_DEST (NUM_DEST),
    .SEL_W    (SEL_W)
  ) u_dec (
    .sel          (dest_sel),
    .en           (load),
    .onehot       (bus_wr_en),
    .out_of_range (bad_sel)
  );

  // HI/LO load overrides a bus write aimed at the same slot.
  always_comb begin
    wr_en = bus_wr_en;
    for (int i = 0; i < NUM_DEST; i++) wr_data[i] = bus_in;
    if (hilo_load) begin
      wr_en[HI_IDX]   = 1'b1;
      wr_en[LO_IDX]   = 1'b1;
      wr_data[HI_IDX] = hi_in;
      wr_data[LO_IDX] = lo_in;
    end
  end

  // ---- register stage: slots and write-status flags ----
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      for (int i = 0; i < NUM_DEST; i++) slot_q[i] <= '0;
      write_done <= 1'b0;
      last_dest  <= '0;
      sel_err    <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_DEST; i++) begin
        if (wr_en[i]) slot_q[i] <= wr_data[i];
      end
      write_done <= (|bus_wr_en) || hilo_load;
      sel_err    <= bad_sel;
      if (|bus_wr_en) last_dest <= dest_sel;
    end
  end

  // Slot 0 reads as zero while ba_out is high; storage is unaffected.
  assign slot_out0  = ba_out ? '0 : slot_q[0];
  assign slot_out1  = slot_q[1];
  assign slot_out2  = slot_q[2];
  assign slot_out3  = slot_q[3];
  assign slot_out4  = slot_q[4];
  assign slot_out5  = slot_q[5];
  assign slot_out6  = slot_q[6];
  assign slot_out7  = slot_q[7];
  assign slot_out8  = slot_q[8];
  assign slot_out9  = slot_q[9];
  assign slot_out10 = slot_q[10];
  assign slot_out11 = slot_q[11];
  assign slot_out12 = slot_q[12];
  assign slot_out13 = slot_q[13];
  assign slot_out14 = slot_q[14];
  assign slot_out15 = slot_q[15];
  assign slot_out16 = slot_q[16];
  assign slot_out17 = slot_q[17];
  assign slot_out18 = slot_q[18];
  assign slot_out19 = slot_q[19];
  assign slot_out20 = slot_q[20];
  assign slot_out21 = slot_q[21];
  assign slot_out22 = slot_q[22];
  assign slot_out23 = slot_q[23];

endmodule

// File: tb/tb_bus_dest_regbank.sv
// Bench for bus_dest_regbank: directed vector table, corner-case sequences and
// randomized traffic against a slot-array reference model.
module tb_bus_dest_regbank;

  logic        clock;
  logic        clear;
  logic [31:0] bus_in;
  logic [4:0]  dest_sel;
  logic        load;
  logic        hilo_load;
  logic [31:0] hi_in;
  logic [31:0] lo_in;
  logic        ba_out;
  wire  [31:0] so [24];
  wire         write_done;
  wire  [4:0]  last_dest;
  wire         sel_err;

  int checks;
  int failures;

  // reference model state
  logic [31:0] m_slot [24];
  logic [4:0]  m_last;
  logic        m_wd;
  logic        m_se;

  bus_dest_regbank dut (
    .clock      (clock),
    .clear      (clear),
    .bus_in     (bus_in),
    .dest_sel   (dest_sel),
    .load       (load),
    .hilo_load  (hilo_load),
    .hi_in      (hi_in),
    .lo_in      (lo_in),
    .ba_out     (ba_out),
    .slot_out0  (so[0]),
    .slot_out1  (so[1]),
    .slot_out2  (so[2]),
    .slot_out3  (so[3]),
    .slot_out4  (so[4]),
    .slot_out5  (so[5]),
    .slot_out6  (so[6]),
    .slot_out7  (so[7]),
    .slot_out8  (so[8]),
    .slot_out9  (so[9]),
    .slot_out10 (so[10]),
    .slot_out11 (so[11]),
    .slot_out12 (so[12]),
    .slot_out13 (so[13]),
    .slot_out14 (so[14]),
    .slot_out15 (so[15]),
    .slot_out16 (so[16]),
    .slot_out17 (so[17]),
    .slot_out18 (so[18]),
    .slot_out19 (so[19]),
    .slot_out20 (so[20]),
    .slot_out21 (so[21]),
    .slot_out22 (so[22]),
    .slot_out23 (so[23]),
    .write_done (write_done),
    .last_dest  (last_dest),
    .sel_err    (sel_err)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    load      = 1'b0;
    hilo_load = 1'b0;
    dest_sel  = '0;
    bus_in    = '0;
    hi_in     = '0;
    lo_in     = '0;
  endtask

  // Spec-level model of one clock edge with the currently driven inputs.
  task automatic model_edge();
    bit bus_ok;
    bus_ok = load && (dest_sel < 5'd24);
    if (hilo_load) begin
      m_slot[16] = hi_in;
      m_slot[17] = lo_in;
    end
    if (bus_ok && !(hilo_load && (dest_sel == 5'd16 || dest_sel == 5'd17)))
      m_slot[dest_sel] = bus_in;
    if (bus_ok) m_last = dest_sel;
    m_wd = bus_ok || hilo_load;
    m_se = load && (dest_sel >= 5'd24);
  endtask

  task automatic model_clear();
    for (int i = 0; i < 24; i++) m_slot[i] = '0;
    m_last = '0;
    m_wd   = 1'b0;
    m_se   = 1'b0;
  endtask

  task automatic chk_all(input string tag);
    for (int i = 0; i < 24; i++)
      chk($sformatf("%s slot%0d", tag, i), so[i],
          (i == 0 && ba_out) ? 32'h0 : m_slot[i]);
    chk({tag, " write_done"}, {31'b0, write_done}, {31'b0, m_wd});
    chk({tag, " sel_err"},    {31'b0, sel_err},    {31'b0, m_se});
    chk({tag, " last_dest"},  {27'b0, last_dest},  {27'b0, m_last});
  endtask

  typedef struct {
    logic        ld;
    logic        hl;
    logic [4:0]  sel;
    logic [31:0] bus;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cslot;
    logic [31:0] eslot;
    logic        ewd;
    logic        ese;
    logic [4:0]  elast;
  } vec_t;

  vec_t vecs [9];

  initial begin
    checks   = 0;
    failures = 0;
    ba_out   = 1'b0;
    idle_inputs();
    model_clear();

    vecs[0] = '{1'b1, 1'b0, 5'd20, 32'h0000_0100, 32'h0, 32'h0, 20, 32'h0000_0100, 1'b1, 1'b0, 5'd20};
    vecs[1] = '{1'b1, 1'b0, 5'd27, 32'h0000_FFFF, 32'h0, 32'h0, 20, 32'h0000_0100, 1'b0, 1'b1, 5'd20};
    vecs[2] = '{1'b1, 1'b1, 5'd17, 32'h0000_0055, 32'h1, 32'hFFFF_FFFE, 17, 32'hFFFF_FFFE, 1'b1, 1'b0, 5'd17};
    vecs[3] = '{1'b0, 1'b0, 5'd0,  32'h0,         32'h0, 32'h0, 16, 32'h0000_0001, 1'b0, 1'b0, 5'd17};
    vecs[4] = '{1'b1, 1'b0, 5'd0,  32'h0000_1234, 32'h0, 32'h0, 0,  32'h0000_1234, 1'b1, 1'b0, 5'd0};
    vecs[5] = '{1'b1, 1'b1, 5'd3,  32'hA5A5_A5A5, 32'h77, 32'h88, 3, 32'hA5A5_A5A5, 1'b1, 1'b0, 5'd3};
    vecs[6] = '{1'b0, 1'b0, 5'd0,  32'h0,         32'h0, 32'h0, 16, 32'h0000_0077, 1'b0, 1'b0, 5'd3};
    vecs[7] = '{1'b1, 1'b0, 5'd31, 32'hDEAD_0000, 32'h0, 32'h0, 3,  32'hA5A5_A5A5, 1'b0, 1'b1, 5'd3};
    vecs[8] = '{1'b0, 1'b1, 5'd0,  32'h0,  32'hAAAA_0000, 32'h5555, 17, 32'h0000_5555, 1'b1, 1'b0, 5'd3};

    // reset state
    clear = 1'b1;
    @(posedge clock);
    #1;
    chk_all("reset");
    @(negedge clock);
    clear = 1'b0;

    // directed table
    for (int v = 0; v < 9; v++) begin
      @(negedge clock);
      load = vecs[v].ld; hilo_load = vecs[v].hl; dest_sel = vecs[v].sel;
      bus_in = vecs[v].bus; hi_in = vecs[v].hi; lo_in = vecs[v].lo;
      model_edge();
      @(posedge clock);
      #1;
      chk($sformatf("vec%0d slot%0d", v, vecs[v].cslot), so[vecs[v].cslot], vecs[v].eslot);
      chk($sformatf("vec%0d write_done", v), {31'b0, write_done}, {31'b0, vecs[v].ewd});
      chk($sformatf("vec%0d sel_err", v),    {31'b0, sel_err},    {31'b0, vecs[v].ese});
      chk($sformatf("vec%0d last_dest", v),  {27'b0, last_dest},  {27'b0, vecs[v].elast});
    end
    @(negedge clock);
    idle_inputs();
    model_edge();
    @(posedge clock);
    #1;
    chk_all("after table");

    // asynchronous clear between edges with a write in flight
    @(negedge clock);
    load = 1'b1; dest_sel = 5'd5; bus_in = 32'hDEAD_BEEF;
    model_edge();
    @(posedge clock);
    #1;
    chk("pre-clear slot5", so[5], 32'hDEAD_BEEF);
    #2;
    clear = 1'b1;
    #1;
    model_clear();
    chk_all("async clear");
    @(negedge clock);
    clear = 1'b0;
    idle_inputs();

    // ba_out gating of slot 0, write under ba_out still stores
    @(negedge clock);
    ba_out = 1'b1; load = 1'b1; dest_sel = 5'd0; bus_in = 32'h0000_1234;
    model_edge();
    @(posedge clock);
    #1;
    chk("ba_out=1 slot0", so[0], 32'h0);
    ba_out = 1'b0;
    #1;
    chk("ba_out=0 slot0", so[0], 32'h0000_1234);
    ba_out = 1'b1;
    #1;
    chk("ba_out=1 again slot0", so[0], 32'h0);
    ba_out = 1'b0;
    @(negedge clock);
    idle_inputs();

    // sweep codes 0..23 back to back
    for (int c = 0; c < 24; c++) begin
      @(negedge clock);
      load = 1'b1; dest_sel = 5'(c); bus_in = 32'(c) * 32'h0101_0101;
      model_edge();
      @(posedge clock);
      #1;
      chk($sformatf("sweep%0d write_done", c), {31'b0, write_done}, 32'h1);
      chk($sformatf("sweep%0d last_dest", c), {27'b0, last_dest}, 32'(c));
    end
    @(negedge clock);
    idle_inputs();
    model_edge();
    @(posedge clock);
    #1;
    for (int c = 0; c < 24; c++)
      chk($sformatf("sweep slot%0d", c), so[c], 32'(c) * 32'h0101_0101);
    chk("sweep end write_done", {31'b0, write_done}, 32'h0);

    // randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      @(negedge clock);
      load      = ($urandom_range(0, 3) != 0);
      hilo_load = ($urandom_range(0, 4) == 0);
      dest_sel  = ($urandom_range(0, 5) == 0) ? 5'($urandom_range(16, 17)) : 5'($urandom_range(0, 31));
      bus_in    = $urandom;
      hi_in     = $urandom;
      lo_in     = $urandom;
      ba_out    = ($urandom_range(0, 3) == 0);
      model_edge();
      @(posedge clock);
      #1;
      chk_all($sformatf("rand%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
